cache_req_dispatch: RTL and testbench
=====================================

CACHE_REQ_DISPATCH -- requirements
Module: cache_req_dispatch

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 5, giving the request-tag width, matching the merge-stage payload.
REQ-002 SHALL have parameter DEPTH, default 4, giving the tag FIFO entries; must be a power of two, at least 2.
REQ-003 SHALL have parameter TIMEOUT, default 255, giving the maximum WAIT_RSP cycles; range 1..255.
REQ-004 SHALL use one clock and a synchronous, active-low reset: clk, rstn.
REQ-005 SHALL have port clk, input, 1 bit: system clock; all state updates on its rising edge.
REQ-006 SHALL have port rstn, input, 1 bit: synchronous active-low reset.
REQ-007 SHALL have port i_drive, input, 1 bit: single-cycle, clk-synchronous push strobe from the merge stage.
REQ-008 SHALL have port i_data, input, DATA_WIDTH bits: tag, sampled when i_drive=1.
REQ-009 SHALL have port o_free, output, 1 bit: single-cycle acknowledge pulse per accepted push.
REQ-010 SHALL have port o_req_valid, output, 1 bit: lookup request valid.
REQ-011 SHALL have port o_req_tag, output, DATA_WIDTH bits: FIFO head tag.
REQ-012 SHALL have port i_req_ready, input, 1 bit: cache tag pipeline accepts the request.
REQ-013 SHALL have port i_hit, input, 1 bit: lookup response, hit.
REQ-014 SHALL have port i_miss, input, 1 bit: lookup response, miss.
REQ-015 SHALL have port i_refill_done, input, 1 bit: miss refill complete.
REQ-016 SHALL have port o_count, output, clog2(DEPTH)+1 bits: FIFO occupancy.
REQ-017 SHALL have port o_busy, output, 1 bit: 1 whenever the FSM is not in IDLE.
REQ-018 SHALL have port o_overflow, output, 1 bit: sticky flag for a dropped push.
REQ-019 SHALL have port o_timeout, output, 1 bit: single-cycle pulse on a response timeout.

Function
REQ-020 SHALL accept a push when i_drive=1 and registered o_count<DEPTH; write i_data at the write pointer; pointer wraps modulo DEPTH.
REQ-021 SHALL pulse o_free for exactly one cycle, in the cycle after each accepted push.
REQ-022 SHALL drop a push when i_drive=1 and o_count==DEPTH: no write, no o_free, o_overflow set to 1 until reset.
REQ-023 SHALL use no same-cycle bypass: fullness is judged on registered o_count, even if a pop occurs in the same cycle.
REQ-024 SHALL leave o_count unchanged on a simultaneous accepted push and pop; otherwise o_count increments by 1 per push and decrements by 1 per pop.
REQ-025 SHALL implement the FSM states IDLE, ISSUE, WAIT_RSP and REFILL.
REQ-026 SHALL transition IDLE->ISSUE when o_count>0; a push in cycle N gives o_req_valid=1 in cycle N+2 at the earliest.
REQ-027 SHALL, in ISSUE, drive o_req_valid=1 and o_req_tag=head entry, held stable until i_req_ready=1.
REQ-028 SHALL, when i_req_ready=1 in ISSUE, pop the head and go to WAIT_RSP with the timeout counter cleared.
REQ-029 SHALL, in WAIT_RSP: on i_hit only, go to IDLE; on i_miss, go to REFILL; on i_hit and i_miss together, treat the event as a miss.
REQ-030 SHALL, in WAIT_RSP with no response, increment the counter; when the counter reaches TIMEOUT, pulse o_timeout once and go to IDLE.
REQ-031 SHALL, in REFILL, wait for i_refill_done=1 and then go to IDLE; i_hit, i_miss and i_req_ready are ignored in this state.
REQ-032 SHALL ignore i_hit and i_miss outside WAIT_RSP.
REQ-033 SHALL drive o_req_valid=0 and o_req_tag=0 in every state other than ISSUE.
REQ-034 SHALL keep pushes accepted in every FSM state.

Reset
REQ-035 SHALL, when rstn=0 at a clk edge, clear both FIFO pointers, o_count, the FSM (to IDLE), the timeout counter, o_free, o_req_valid, o_req_tag, o_busy, o_overflow and o_timeout.
REQ-036 SHALL, on reset mid-operation, discard queued tags and any pending o_free without emitting pulses; a push coinciding with rstn=0 is ignored.

Verification
REQ-037 SHALL cover: push tag 5'h0A at cycle 0 with i_req_ready=1 -> o_free=1 at cycle 1, o_req_valid=1 with tag 0x0A at cycle 2, i_hit at cycle 4 -> IDLE with o_count=0.
REQ-038 SHALL cover: five consecutive pushes 1..5 with i_req_ready=0 -> o_count=4, four o_free pulses, o_overflow=1, and later issue order 1,2,3,4.
REQ-039 SHALL cover: i_hit and i_miss asserted together in WAIT_RSP -> REFILL; i_refill_done 10 cycles later -> IDLE, then ISSUE of the next queued tag.
REQ-040 SHALL cover: with TIMEOUT=3 and no response -> exactly one o_timeout pulse on the 3rd WAIT_RSP cycle, then IDLE.
REQ-041 SHALL cover: push and pop in the same cycle at o_count=2 -> o_count stays 2 and o_free pulses once.
REQ-042 SHALL cover: rstn=0 for one cycle with 3 entries queued in ISSUE -> next cycle all outputs 0, o_count=0, no o_free or o_req_valid.

Source files
------------

// File: rtl/cache_req_dispatch.sv
// Request dispatcher between the merge stage and the cache tag pipeline.
// A tag FIFO feeds an issue/wait/refill FSM with a bounded response wait.
module cache_req_dispatch #(
  parameter int DATA_WIDTH = 5,
  parameter int DEPTH      = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     i_drive,
  input  logic [DATA_WIDTH-1:0]    i_data,
  output logic                     o_free,
  output logic                     o_req_valid,
  output logic [DATA_WIDTH-1:0]    o_req_tag,
  input  logic                     i_req_ready,
  input  logic                     i_hit,
  input  logic                     i_miss,
  input  logic                     i_refill_done,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_busy,
  output logic                     o_overflow,
  output logic                     o_timeout
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP, REFILL} state_t;

  state_t                state, next_state;
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [7:0]            timer;
  logic                  push, pop, no_rsp, timed_out;

  // Fullness is judged on the registered count only; a same-cycle pop does not free a slot.
  assign push      = i_drive && (o_count < CW'(DEPTH));
  assign pop       = (state == ISSUE) && i_req_ready;
  assign no_rsp    = !i_hit && !i_miss;
  assign timed_out = (state == WAIT_RSP) && no_rsp && (timer == 8'(TIMEOUT - 1));

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      o_count    <= '0;
      o_free     <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      o_free <= push;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   o_count <= o_count + 1'b1;
        2'b01:   o_count <= o_count - 1'b1;
        default: o_count <= o_count;
      endcase
      if (i_drive && !push) o_overflow <= 1'b1;
    end
  end

  // NOTE: tag storage has no reset; the pointers and count alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (rstn && push) mem[wr_ptr] <= i_data;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= IDLE;
      timer <= '0;
    end else begin
      state <= next_state;
      if (pop)
        timer <= '0;
      else if (state == WAIT_RSP && no_rsp)
        timer <= timer + 1'b1;
    end
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (o_count != '0) next_state = ISSUE;
      ISSUE:    if (i_req_ready)   next_state = WAIT_RSP;
      WAIT_RSP: begin
        // A simultaneous hit and miss is resolved as a miss.
        if (i_miss)         next_state = REFILL;
        else if (i_hit)     next_state = IDLE;
        else if (timed_out) next_state = IDLE;
      end
      REFILL:   if (i_refill_done) next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  always_comb begin
    o_req_valid = 1'b0;
    o_req_tag   = '0;
    o_busy      = (state != IDLE);
    o_timeout   = timed_out;
    if (state == ISSUE) begin
      o_req_valid = 1'b1;
      o_req_tag   = mem[rd_ptr];
    end
  end

endmodule

// File: tb/tb_cache_req_dispatch.sv
// Bench for cache_req_dispatch: a vector table for the basic hit flow plus
// hand sequences for overflow, hit+miss refill, timeout, push/pop and reset.
module tb_cache_req_dispatch;
  localparam int DW    = 5;
  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          i_drive = 1'b0;
  logic [DW-1:0] i_data = '0;
  logic          i_req_ready = 1'b0;
  logic          i_hit = 1'b0;
  logic          i_miss = 1'b0;
  logic          i_refill_done = 1'b0;
  logic          o_free, o_req_valid, o_busy, o_overflow, o_timeout;
  logic [DW-1:0] o_req_tag;
  logic [CW-1:0] o_count;

  int n_checks = 0;
  int n_errors = 0;
  int free_cnt = 0;
  int to_cnt   = 0;
  logic [DW-1:0] sb_q [$];
  logic [DW-1:0] mon_tag;
  bit            done;

  typedef struct packed {
    logic          d;
    logic [DW-1:0] dat;
    logic          rdy;
    logic          hit;
    logic          ef;
    logic          ev;
    logic [DW-1:0] et;
    logic [CW-1:0] ec;
    logic          eb;
  } vec_t;

  vec_t tbl [6];

  cache_req_dispatch #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .TIMEOUT(3)) dut (
    .clk(clk), .rstn(rstn), .i_drive(i_drive), .i_data(i_data), .o_free(o_free),
    .o_req_valid(o_req_valid), .o_req_tag(o_req_tag), .i_req_ready(i_req_ready),
    .i_hit(i_hit), .i_miss(i_miss), .i_refill_done(i_refill_done), .o_count(o_count),
    .o_busy(o_busy), .o_overflow(o_overflow), .o_timeout(o_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard side: every accepted issue must match the oldest queued tag.
  always @(negedge clk) begin
    if (rstn) begin
      if (o_free)    free_cnt++;
      if (o_timeout) to_cnt++;
      if (o_req_valid && i_req_ready) begin
        if (sb_q.size() == 0) begin
          check("issue_unexpected", 32'(o_req_tag), 32'hFFFF_FFFF);
        end else begin
          mon_tag = sb_q.pop_front();
          check("issue_order", 32'(o_req_tag), 32'(mon_tag));
        end
      end
    end
  end

  // Inputs change 1 time unit after the rising edge; outputs are inspected 1 unit later.
  task automatic drive(input logic d, input logic [DW-1:0] dat, input logic rdy,
                       input logic hit, input logic miss, input logic refill);
    @(posedge clk);
    #1;
    i_drive = d; i_data = dat; i_req_ready = rdy;
    i_hit = hit; i_miss = miss; i_refill_done = refill;
    if (d && rstn && sb_q.size() < DEPTH) sb_q.push_back(dat);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset(input logic push_during);
    @(posedge clk);
    #1;
    rstn = 1'b0; i_drive = push_during; i_data = 5'h1F;
    i_req_ready = 1'b0; i_hit = 1'b0; i_miss = 1'b0; i_refill_done = 1'b0;
    sb_q.delete();
    @(posedge clk);
    #1;
    rstn = 1'b1; i_drive = 1'b0;
    #1;
  endtask

  task automatic wait_pop(input string name);
    done = 1'b0;
    for (int i = 0; i < 10 && !done; i++) begin
      drive(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
      if (o_req_valid) done = 1'b1;
    end
    if (!done) check(name, 32'(o_req_valid), 32'd1);
  endtask

  function automatic logic [31:0] all_out();
    return 32'({o_free, o_req_valid, o_req_tag, o_count, o_busy, o_overflow, o_timeout});
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got time limit expected completion");
    $fatal(1, "time limit reached");
  end

  initial begin
    //              d     dat    rdy   hit   ef    ev    et     ec    eb
    tbl[0] = '{1'b1, 5'h0A, 1'b1, 1'b0, 1'b0, 1'b0, 5'h00, 3'd0, 1'b0};
    tbl[1] = '{1'b0, 5'h00, 1'b1, 1'b0, 1'b1, 1'b0, 5'h00, 3'd1, 1'b0};
    tbl[2] = '{1'b0, 5'h00, 1'b1, 1'b0, 1'b0, 1'b1, 5'h0A, 3'd1, 1'b1};
    tbl[3] = '{1'b0, 5'h00, 1'b1, 1'b0, 1'b0, 1'b0, 5'h00, 3'd0, 1'b1};
    tbl[4] = '{1'b0, 5'h00, 1'b1, 1'b1, 1'b0, 1'b0, 5'h00, 3'd0, 1'b1};
    tbl[5] = '{1'b0, 5'h00, 1'b1, 1'b0, 1'b0, 1'b0, 5'h00, 3'd0, 1'b0};

    do_reset(1'b0);
    check("reset_outputs", all_out(), 32'd0);

    // Single tag, immediate ready, hit on the second wait cycle.
    for (int i = 0; i < 6; i++) begin
      drive(tbl[i].d, tbl[i].dat, tbl[i].rdy, tbl[i].hit, 1'b0, 1'b0);
      check($sformatf("basic_row%0d", i), all_out(),
            32'({tbl[i].ef, tbl[i].ev, tbl[i].et, tbl[i].ec, tbl[i].eb, 1'b0, 1'b0}));
    end

    // Five pushes into a four-entry FIFO: last one dropped, order preserved.
    free_cnt = 0;
    for (int i = 1; i <= 5; i++) drive(1'b1, DW'(i), 1'b0, 1'b0, 1'b0, 1'b0);
    idle();
    idle();
    check("ovf_count", 32'(o_count), 32'd4);
    check("ovf_flag", 32'(o_overflow), 32'd1);
    check("ovf_free_pulses", 32'(free_cnt), 32'd4);
    check("ovf_head", 32'({o_req_valid, o_req_tag}), 32'({1'b1, 5'd1}));
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      drive(1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0);
      if (sb_q.size() == 0 && !o_busy) done = 1'b1;
    end
    check("ovf_drained", 32'(done), 32'd1);
    check("ovf_count_empty", 32'(o_count), 32'd0);
    check("ovf_sticky", 32'(o_overflow), 32'd1);

    // Hit and miss together resolve as a miss; refill ignores hit/ready.
    do_reset(1'b0);
    check("rst_clears_ovf", 32'(o_overflow), 32'd0);
    drive(1'b1, 5'h07, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 5'h09, 1'b0, 1'b0, 1'b0, 1'b0);
    wait_pop("refill_issue_wait");
    drive(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
    check("hitmiss_busy", 32'(o_busy), 32'd1);
    for (int i = 0; i < 9; i++) begin
      drive(1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0);
      check("refill_hold", 32'({o_req_valid, o_busy, o_count}), 32'({1'b0, 1'b1, 3'd1}));
    end
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("refill_done_cycle", 32'(o_busy), 32'd1);
    idle();
    check("refill_idle", 32'({o_busy, o_req_valid}), 32'd0);
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("refill_next_issue", 32'({o_req_valid, o_req_tag}), 32'({1'b1, 5'h09}));
    drive(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle();
    check("refill_end", 32'({o_busy, o_count}), 32'd0);

    // No response: timeout pulse on the third wait cycle, then idle.
    drive(1'b1, 5'h03, 1'b0, 1'b0, 1'b0, 1'b0);
    wait_pop("to_issue_wait");
    to_cnt = 0;
    idle();
    check("to_wait1", 32'({o_timeout, o_busy}), 32'({1'b0, 1'b1}));
    idle();
    check("to_wait2", 32'({o_timeout, o_busy}), 32'({1'b0, 1'b1}));
    idle();
    check("to_wait3", 32'({o_timeout, o_busy}), 32'({1'b1, 1'b1}));
    idle();
    check("to_after", 32'({o_timeout, o_busy}), 32'd0);
    idle();
    check("to_pulses", 32'(to_cnt), 32'd1);

    // Push and pop in the same cycle at occupancy 2.
    drive(1'b1, 5'h11, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 5'h12, 1'b0, 1'b0, 1'b0, 1'b0);
    idle();
    idle();
    check("pp_pre", 32'({o_req_valid, o_req_tag, o_count}), 32'({1'b1, 5'h11, 3'd2}));
    free_cnt = 0;
    drive(1'b1, 5'h13, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("pp_count", 32'({o_count, o_free}), 32'({3'd2, 1'b1}));
    idle();
    check("pp_free_once", 32'({free_cnt, o_free}), 32'({31'd1, 1'b0}));

    // Reset with three entries queued in ISSUE and an o_free pending.
    drive(1'b1, 5'h14, 1'b0, 1'b0, 1'b0, 1'b0);
    check("rst_pre", 32'({o_req_valid, o_count}), 32'({1'b1, 3'd2}));
    do_reset(1'b1);
    check("rst_mid_outputs", all_out(), 32'd0);
    free_cnt = 0;
    idle();
    idle();
    check("rst_quiet", 32'({free_cnt, o_req_valid, o_count}), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
